// File: rtl/jt5205_pkg.sv
// rtl/jt5205_pkg.sv - tables, types and arithmetic helpers shared by the multi-channel ADPCM decoder
package jt5205_pkg;

  localparam int IDX_MAX = 48;
  localparam int SMP_MAX = 2047;
  localparam int SMP_MIN = -2048;

  localparam logic [11:0] STEP_TBL [49] = '{
    12'd16,   12'd17,   12'd19,   12'd21,   12'd23,   12'd25,   12'd28,
    12'd31,   12'd34,   12'd37,   12'd41,   12'd45,   12'd50,   12'd55,
    12'd60,   12'd66,   12'd73,   12'd80,   12'd88,   12'd97,   12'd107,
    12'd118,  12'd130,  12'd143,  12'd157,  12'd173,  12'd190,  12'd209,
    12'd230,  12'd253,  12'd279,  12'd307,  12'd337,  12'd371,  12'd408,
    12'd449,  12'd494,  12'd544,  12'd598,  12'd658,  12'd724,  12'd796,
    12'd876,  12'd963,  12'd1060, 12'd1166, 12'd1282, 12'd1411, 12'd1552
  };

  localparam int IDX_ADJ [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  // Divider limits per sel code; 0 marks the stopped rate
  localparam int DIV_LIM [4] = '{96, 64, 48, 0};

  typedef enum logic [1:0] {
    RATE_96   = 2'd0,
    RATE_64   = 2'd1,
    RATE_48   = 2'd2,
    RATE_STOP = 2'd3
  } rate_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] ch;
    logic [3:0] nib;
    logic       empty;
  } eng_s1_t;

  function automatic logic [6:0] lim_of(input logic [1:0] s);
    return 7'(DIV_LIM[s]);
  endfunction

  function automatic logic signed [11:0] clamp_smp(input int v);
    if (v > SMP_MAX) return 12'(SMP_MAX);
    else if (v < SMP_MIN) return 12'(SMP_MIN);
    else return 12'(v);
  endfunction

  function automatic int sat_int(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic int adpcm_diff(input int step, input logic [3:0] nib);
    int d;
    d = step >>> 3;
    if (nib[2]) d = d + step;
    if (nib[1]) d = d + (step >>> 1);
    if (nib[0]) d = d + (step >>> 2);
    return nib[3] ? -d : d;
  endfunction

  function automatic logic [5:0] next_idx(input logic [5:0] idx, input logic [2:0] mag);
    int v;
    v = int'(idx) + IDX_ADJ[mag];
    if (v < 0) v = 0;
    if (v > IDX_MAX) v = IDX_MAX;
    return 6'(v);
  endfunction

endpackage

// File: rtl/jt5205_mch_fifo.sv
// rtl/jt5205_mch_fifo.sv - single-channel nibble FIFO with full/low/count and sticky underrun
module jt5205_mch_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [3:0]               din,
  input  logic                     pop,
  output logic [3:0]               dout,
  output logic                     full,
  output logic                     low,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW + 1)'(DEPTH / 2);

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          underrun_q, underrun_d;
  logic          pop_ok, push_ok;

  // A pop frees a slot in the same clk, so a full FIFO still accepts a write alongside it
  always_comb begin
    pop_ok     = pop && (count_q != '0);
    push_ok    = push && ((count_q != FULL_CNT) || pop_ok);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    underrun_d = underrun_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    if (pop && (count_q == '0)) underrun_d = 1'b1;
    else if (push) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout     = mem_q[rd_ptr_q];
  assign full     = (count_q == FULL_CNT);
  assign low      = (count_q < HALF_CNT);
  assign underrun = underrun_q;
  assign count    = count_q;

endmodule

// File: rtl/jt5205_mch.sv
// rtl/jt5205_mch.sv - multi-channel ADPCM decoder with shared step engine and saturated mix
// Optional JT5205M_DECAY_EN: an underrun decays the sample toward 0 instead of holding it.
module jt5205_mch
  import jt5205_pkg::*;
#(
  parameter int CH         = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int OUTW       = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [2*CH-1:0]        sel,
  input  logic [CH-1:0]          we,
  input  logic [4*CH-1:0]        din,
  output logic [CH-1:0]          full,
  output logic [CH-1:0]          low,
  output logic [CH-1:0]          underrun,
  output logic [12*CH-1:0]       sound_ch,
  output logic signed [OUTW-1:0] mix,
  output logic                   sample
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [6:0]           cnt_q [CH];
  logic [6:0]           cnt_d [CH];
  logic [CH-1:0]        tick;
  logic [CH-1:0]        pend_q, pend_d;
  logic [CH-1:0]        grant;
  logic [2:0]           pick;
  eng_s1_t              s1_q, s1_d;
  logic signed [11:0]   acc_q [CH];
  logic signed [11:0]   acc_d [CH];
  logic [5:0]           idx_q [CH];
  logic [5:0]           idx_d [CH];
  logic                 upd_q, upd_d;
  logic signed [OUTW-1:0] mix_q, mix_d;
  logic                 sample_q, sample_d;
  logic [3:0]           fifo_dout [CH];
  logic [CW-1:0]        fifo_cnt [CH];

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jt5205_mch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (we[g]),
      .din      (din[4*g +: 4]),
      .pop      (grant[g]),
      .dout     (fifo_dout[g]),
      .full     (full[g]),
      .low      (low[g]),
      .underrun (underrun[g]),
      .count    (fifo_cnt[g])
    );
    assign sound_ch[12*g +: 12] = acc_q[g];
  end

  // Rate dividers; >= keeps a lowered limit from running past its wrap point
  always_comb begin
    tick = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cen) begin
        if (rate_e'(sel[2*i +: 2]) == RATE_STOP) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= lim_of(sel[2*i +: 2]) - 7'd1) begin
          tick[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 7'd1;
        end
      end
    end
  end

  // Descending scan leaves the lowest pending channel granted
  always_comb begin
    grant = '0;
    pick  = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        pick     = 3'(i);
      end
    end
    pend_d = (pend_q & ~grant) | tick;
  end

  always_comb begin
    s1_d     = '0;
    s1_d.vld = |pend_q;
    s1_d.ch  = pick;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        s1_d.nib   = fifo_dout[i];
        s1_d.empty = (fifo_cnt[i] == '0);
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    upd_d = s1_q.vld;
    for (int i = 0; i < CH; i++) begin
      if (s1_q.vld && (s1_q.ch == 3'(i))) begin
        if (s1_q.empty) begin
`ifdef JT5205M_DECAY_EN
          acc_d[i] = acc_q[i] - (acc_q[i] >>> 4);
`endif
        end else begin
          acc_d[i] = clamp_smp(int'(acc_q[i]) + adpcm_diff(int'(STEP_TBL[idx_q[i]]), s1_q.nib));
          idx_d[i] = next_idx(idx_q[i], s1_q.nib[2:0]);
        end
      end
    end
  end

  always_comb begin
    int sum;
    sum      = 0;
    mix_d    = mix_q;
    sample_d = upd_q;
    for (int i = 0; i < CH; i++) sum = sum + int'(acc_q[i]);
    if (upd_q) mix_d = OUTW'(sat_int(sum, OUTW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
        acc_q[i] <= '0;
        idx_q[i] <= '0;
      end
      pend_q   <= '0;
      s1_q     <= '0;
      upd_q    <= 1'b0;
      mix_q    <= '0;
      sample_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      s1_q     <= s1_d;
      upd_q    <= upd_d;
      mix_q    <= mix_d;
      sample_q <= sample_d;
    end
  end

  assign mix    = mix_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_jt5205_mch.sv
// tb/tb_jt5205_mch.sv - directed self-checking bench for jt5205_mch (CH=2, FIFO_DEPTH=8, OUTW=14)
module tb_jt5205_mch;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cen = 1'b1;
  logic [3:0]        sel = 4'hF;
  logic [1:0]        we = 2'b00;
  logic [7:0]        din = 8'h00;
  logic [1:0]        full, low, underrun;
  logic [23:0]       sound_ch;
  logic signed [13:0] mix;
  logic              sample;

  int checks = 0;
  int failures = 0;
  int m_acc [2] = '{0, 0};
  int m_idx [2] = '{0, 0};
  int step_tb [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73,
                       80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279,
                       307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
                       1060, 1166, 1282, 1411, 1552};

`ifdef JT5205M_DECAY_EN
  localparam int EXP_UR160 = 150;
`else
  localparam int EXP_UR160 = 160;
`endif

  always #5 clk = ~clk;

  jt5205_mch #(.CH(2), .FIFO_DEPTH(8), .OUTW(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .sel      (sel),
    .we       (we),
    .din      (din),
    .full     (full),
    .low      (low),
    .underrun (underrun),
    .sound_ch (sound_ch),
    .mix      (mix),
    .sample   (sample)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] snd(input int c);
    logic signed [11:0] t;
    t = sound_ch[12*c +: 12];
    return t;
  endfunction

  task automatic model_nib(input int c, input int n);
    int st, d, ix;
    st = step_tb[m_idx[c]];
    d = st / 8 + (((n & 4) != 0) ? st : 0) + (((n & 2) != 0) ? st / 2 : 0) + (((n & 1) != 0) ? st / 4 : 0);
    if ((n & 8) != 0) d = -d;
    m_acc[c] = m_acc[c] + d;
    if (m_acc[c] > 2047) m_acc[c] = 2047;
    if (m_acc[c] < -2048) m_acc[c] = -2048;
    ix = m_idx[c] + (((n & 4) != 0) ? 2 * ((n & 3) + 1) : -1);
    m_idx[c] = (ix < 0) ? 0 : ((ix > 48) ? 48 : ix);
  endtask

  task automatic model_underrun(input int c);
`ifdef JT5205M_DECAY_EN
    m_acc[c] = m_acc[c] - (m_acc[c] >>> 4);
`else
    m_acc[c] = m_acc[c];
`endif
  endtask

  task automatic wr(input int c, input logic [3:0] n);
    we[c] = 1'b1;
    din[4*c +: 4] = n;
    @(negedge clk);
    we = 2'b00;
  endtask

  task automatic wait_sample(input string tag);
    int n = 0;
    @(negedge clk);
    while (sample !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, 32'(n < 200), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    chk("rst_low_held", low, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_full", full, 0);
    chk("rst_low", low, 2'b11);
    chk("rst_underrun", underrun, 0);
    chk("rst_sound", sound_ch, 0);
    chk("rst_mix", mix, 0);
    chk("rst_sample", sample, 0);

    // ch0 first tick: exact latency from sel change
    wr(0, 4'b0111);
    sel[1:0] = 2'd2;
    model_nib(0, 7);
    repeat (50) @(negedge clk);
    chk("b_snd0_30", snd(0), 30);
    chk("b_sample_lo", sample, 0);
    @(negedge clk);
    chk("b_sample_hi", sample, 1);
    chk("b_mix_30", mix, 30);
    @(negedge clk);
    chk("b_sample_end", sample, 0);
    wr(0, 4'b0000);
    model_nib(0, 0);
    wait_sample("b2");
    chk("b_snd0_34", snd(0), 34);
    chk("b_mix_34", mix, 34);

    // both channels tick on the same cen
    sel = 4'hF;
    we = 2'b11;
    din = 8'b0110_0000;
    @(negedge clk);
    we = 2'b00;
    sel = 4'b1010;
    model_nib(0, 0);
    model_nib(1, 6);
    repeat (50) @(negedge clk);
    chk("c_snd0_37", snd(0), 37);
    chk("c_snd1_pre", snd(1), 0);
    chk("c_sample_lo", sample, 0);
    @(negedge clk);
    chk("c_snd1_26", snd(1), 26);
    chk("c_sample_0", sample, 1);
    chk("c_mix_37", mix, 37);
    @(negedge clk);
    chk("c_sample_1", sample, 1);
    chk("c_mix_63", mix, 63);
    @(negedge clk);
    chk("c_sample_end", sample, 0);

    // ch1 to +160, then underrun
    sel[1:0] = 2'd3;
    wr(1, 4'b0111);
    wr(1, 4'b0101);
    chk("d_low1", low[1], 1);
    model_nib(1, 7);
    wait_sample("d1");
    chk("d_snd1_78", snd(1), 78);
    model_nib(1, 5);
    wait_sample("d2");
    chk("d_snd1_160", snd(1), 160);
    wait_sample("d3");
    model_underrun(1);
    chk("d_underrun", underrun, 2'b10);
    chk("d_snd1_ur", snd(1), EXP_UR160);
    chk("d_mix", mix, m_acc[0] + m_acc[1]);
    sel[3:2] = 2'd3;
    wr(1, 4'b0000);
    chk("d_ur_clear", underrun[1], 0);

    // ch0 FIFO fill past full, then drain in order
    for (int k = 1; k <= 9; k++) begin
      we[0] = 1'b1;
      din[3:0] = 4'(k);
      @(negedge clk);
      if (k == 7) chk("e_full_at7", full[0], 0);
      if (k == 8) chk("e_full_at8", full[0], 1);
    end
    we = 2'b00;
    chk("e_full_at9", full[0], 1);
    chk("e_low_full", low[0], 0);
    sel[1:0] = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      model_nib(0, k);
      wait_sample($sformatf("e_pop%0d", k));
      chk($sformatf("e_snd0_pop%0d", k), snd(0), m_acc[0]);
      if (k == 1) chk("e_full_after_pop", full[0], 0);
    end
    wait_sample("e_ur");
    model_underrun(0);
    chk("e_underrun0", underrun[0], 1);
    chk("e_snd0_ur", snd(0), m_acc[0]);

    // saturation at +2047 with index pinned at 48, then -2048
    for (int k = 0; k < 16; k++) begin
      wr(0, 4'b0111);
      if (k == 0) chk("f_ur_clear", underrun[0], 0);
      model_nib(0, 7);
      wait_sample("f_pos");
    end
    chk("f_snd0_max", snd(0), 2047);
    wr(0, 4'b1111);
    model_nib(0, 15);
    wait_sample("f_neg1");
    chk("f_snd0_step48", snd(0), -863);
    for (int k = 0; k < 15; k++) begin
      wr(0, 4'b1111);
      model_nib(0, 15);
      wait_sample("f_neg");
    end
    chk("f_snd0_min", snd(0), -2048);
    chk("f_mix", mix, m_acc[0] + m_acc[1]);

    // asynchronous reset mid-stream
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("g_sound", sound_ch, 0);
    chk("g_mix", mix, 0);
    chk("g_sample", sample, 0);
    chk("g_full", full, 0);
    chk("g_low", low, 2'b11);
    chk("g_underrun", underrun, 0);
    @(negedge clk);
    sel = 4'hF;
    rst_n = 1'b1;
    @(negedge clk);
    wr(0, 4'b0111);
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sample === 1'b1) pulses++;
    end
    chk("g_stop_pulses", pulses, 0);
    chk("g_stop_snd0", snd(0), 0);
    chk("g_stop_low0", low[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
